alu_slot_issuer: RTL and testbench
==================================

Name: alu_slot_issuer

Overview:
- Upstream issue stage for the 3-phase sequenced 4-bit ALU (IDLE→EXEC→WB, one result every 3 cycles, registered on the WB edge).
- Accepts a ready/valid command stream into a small FIFO.
- Mirrors the ALU phase from the shared reset and holds A/B/op stable for a full 3-cycle slot.
- Captures the ALU result and flags, then returns them tagged as a one-cycle response pulse.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, ≥2)
TAG_W, 4, width of the command/response tag
CNT_W, 16, width of the issued-command counter

Ports:
clk  in  1  clock, shared with the ALU
rst_n  in  1  asynchronous active-low reset, shared with the ALU
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept
cmd_a  in  4  operand A
cmd_b  in  4  operand B
cmd_op  in  2  00 add, 01 sub, 10 and, 11 or
cmd_tag  in  TAG_W  caller tag
alu_a  out  4  to ALU A
alu_b  out  4  to ALU B
alu_op  out  2  to ALU op
alu_result  in  4  ALU result
alu_carry  in  1  ALU carry
alu_zero  in  1  ALU zero
alu_overflow  in  1  ALU overflow
rsp_valid  out  1  one-cycle response pulse
rsp_tag  out  TAG_W  tag of the completed command
rsp_result  out  4  captured result
rsp_flags  out  3  {carry, zero, overflow}
fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy
issued_count  out  CNT_W  commands issued, wraps

Behaviour:
- Reset (async, active-low): all outputs and state clear to 0. This includes phase, FIFO pointers and level, slot/inflight valid bits, rsp_* and issued_count. cmd_ready is 1 after reset because the FIFO is empty.
- Phase counter: 0→1→2→0, advancing every clock. It is 0 in the first cycle after reset release, which keeps it aligned with the ALU state IDLE/EXEC/WB = 0/1/2.
- Cycle numbering: cycle k is the k-th cycle after reset release, so phase = k mod 3.
- FIFO:
  - cmd_ready = (level < DEPTH), registered-level based, with no combinational path from cmd_valid.
  - Enqueue happens on cmd_valid & cmd_ready.
  - There is no bypass. An entry written on an edge is never dequeued on that same edge.
  - Simultaneous enqueue and dequeue leaves the level unchanged.
- Slot load: on the edge ending phase 2, if level > 0 (pre-edge):
  - pop the head into hold regs (a, b, op, tag) and set slot_valid = 1;
  - increment issued_count.
- Empty FIFO at slot load:
  - slot_valid = 0;
  - hold regs are forced to a=0, b=0, op=00 (bubble);
  - issued_count is unchanged.
- alu_a/alu_b/alu_op are driven directly from the hold regs. They are therefore stable through phases 0, 1 and 2 of the slot.
- In-flight tracking: on the same phase-2 edge, before the reload, the current slot_valid/tag are copied to inflight_valid/inflight_tag. This edge is the one on which the ALU writes back the slot's operands.
- Capture: on the edge ending phase 0, if inflight_valid:
  - register alu_result and flags into rsp_*;
  - set rsp_valid = 1 for exactly one cycle (phase 1).
  - Otherwise rsp_valid = 0, and rsp_result/rsp_flags/rsp_tag hold their last values.
- Latency:
  - Command enqueued in cycle 0 → loaded at end of cycle 2 → ALU writeback at end of cycle 5 → rsp_valid in cycle 7.
  - Steady-state throughput is 1 response per 3 cycles.
- No response backpressure: the consumer must accept rsp on the pulse.
- Bubbles produce no response, even though the ALU computes 0+0.
- Responses are returned in command order; tags are returned unchanged.
- issued_count wraps from 2^CNT_W−1 to 0.
- Reset mid-operation: everything, including the FIFO contents and any in-flight slot, is discarded. No rsp pulse is produced for the aborted commands. Phase restarts at 0, re-aligned with the ALU.

Test Plan:
- Single add: cmd {A=5,B=3,op=00,tag=1} valid in cycle 0 → rsp_valid only in cycle 7, rsp_result=8, flags {c=0,z=0,v=1}, tag=1.
- Sub and logic ops: queue {3,5,01,t2}, {A,5,10,t3}, {F,0,11,t4} →
  - t2: result E, flags {1,0,0};
  - t3: result 0, flags {0,1,0};
  - t4: result F, flags {0,0,0};
  - each pulse exactly 3 cycles after the previous one, in order.
- FIFO full: cmd_valid held high cycles 0–9 with DEPTH=4 →
  - cmd_ready first drops when level=4;
  - fifo_level never exceeds 4;
  - no tag is lost or duplicated;
  - issued_count equals the number of responses plus the commands still in the slot/in-flight.
- Empty/bubble: no commands for 12 cycles → rsp_valid stays 0, issued_count stays 0, alu_a/alu_b/alu_op stay 0.
- Reset mid-flight: enqueue 3 commands, assert rst_n=0 in cycle 6 →
  - all outputs are 0 immediately (async);
  - no stale rsp after release;
  - a new command in cycle 0 after release responds in cycle 7.
- Counter wrap: with CNT_W=4, issue 17 commands → issued_count reads 1.

Source files
------------

// File: rtl/alu_slot_issuer_if.sv
// rtl/alu_slot_issuer_if.sv - command, ALU and response signals of the ALU slot issuer
interface alu_slot_issuer_if #(
  parameter int TAG_W = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [3:0]       cmd_a;
  logic [3:0]       cmd_b;
  logic [1:0]       cmd_op;
  logic [TAG_W-1:0] cmd_tag;

  logic [3:0]       alu_a;
  logic [3:0]       alu_b;
  logic [1:0]       alu_op;
  logic [3:0]       alu_result;
  logic             alu_carry;
  logic             alu_zero;
  logic             alu_overflow;

  logic             rsp_valid;
  logic [TAG_W-1:0] rsp_tag;
  logic [3:0]       rsp_result;
  logic [2:0]       rsp_flags;

  // Environment side: produces commands, models the ALU, consumes responses.
  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
    input  cmd_ready,
    input  alu_a, alu_b, alu_op,
    output alu_result, alu_carry, alu_zero, alu_overflow,
    input  rsp_valid, rsp_tag, rsp_result, rsp_flags
  );

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, cmd_tag,
    output cmd_ready,
    output alu_a, alu_b, alu_op,
    input  alu_result, alu_carry, alu_zero, alu_overflow,
    output rsp_valid, rsp_tag, rsp_result, rsp_flags
  );
endinterface

// File: rtl/alu_slot_issuer.sv
// rtl/alu_slot_issuer.sv - FIFO-fed issue stage for a 3-phase sequenced 4-bit ALU
// Holds operands for a full IDLE/EXEC/WB slot and returns tagged results one slot later.
module alu_slot_issuer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_slot_issuer_if.slave         bus,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         issued_count
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;
  localparam int EW    = 4 + 4 + 2 + TAG_W;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_EXEC = 2'd1,
    PH_WB   = 2'd2
  } phase_t;

  phase_t           phase;
  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LVL_W-1:0] level;

  logic [3:0]       hold_a;
  logic [3:0]       hold_b;
  logic [1:0]       hold_op;
  logic [TAG_W-1:0] hold_tag;
  logic             slot_valid;
  logic             inflight_valid;
  logic [TAG_W-1:0] inflight_tag;

  logic             rsp_valid_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic [3:0]       rsp_result_q;
  logic [2:0]       rsp_flags_q;

  logic             cmd_ready;
  logic             push;
  logic             pop;
  logic [EW-1:0]    head;

  assign cmd_ready = (level < LVL_W'(DEPTH));
  assign push      = bus.cmd_valid && cmd_ready;
  assign pop       = (phase == PH_WB) && (level != '0);
  assign head      = mem[rd_ptr];

  // Storage needs no reset: entries are only visible through the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {bus.cmd_a, bus.cmd_b, bus.cmd_op, bus.cmd_tag};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase          <= PH_IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level          <= '0;
      hold_a         <= '0;
      hold_b         <= '0;
      hold_op        <= '0;
      hold_tag       <= '0;
      slot_valid     <= 1'b0;
      inflight_valid <= 1'b0;
      inflight_tag   <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_tag_q      <= '0;
      rsp_result_q   <= '0;
      rsp_flags_q    <= '0;
      issued_count   <= '0;
    end else begin
      case (phase)
        PH_IDLE: phase <= PH_EXEC;
        PH_EXEC: phase <= PH_WB;
        default: phase <= PH_IDLE;
      endcase

      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (push && !pop) begin
        level <= level + LVL_W'(1);
      end else if (!push && pop) begin
        level <= level - LVL_W'(1);
      end

      // The ALU writes back the current slot on this same edge, so hand it to in-flight first.
      if (phase == PH_WB) begin
        inflight_valid <= slot_valid;
        inflight_tag   <= hold_tag;
        if (pop) begin
          {hold_a, hold_b, hold_op, hold_tag} <= head;
          slot_valid   <= 1'b1;
          rd_ptr       <= rd_ptr + AW'(1);
          issued_count <= issued_count + CNT_W'(1);
        end else begin
          hold_a     <= '0;
          hold_b     <= '0;
          hold_op    <= '0;
          hold_tag   <= '0;
          slot_valid <= 1'b0;
        end
      end

      rsp_valid_q <= 1'b0;
      if ((phase == PH_IDLE) && inflight_valid) begin
        rsp_valid_q  <= 1'b1;
        rsp_tag_q    <= inflight_tag;
        rsp_result_q <= bus.alu_result;
        rsp_flags_q  <= {bus.alu_carry, bus.alu_zero, bus.alu_overflow};
      end
    end
  end

  assign bus.cmd_ready  = cmd_ready;
  assign bus.alu_a      = hold_a;
  assign bus.alu_b      = hold_b;
  assign bus.alu_op     = hold_op;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_tag    = rsp_tag_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_flags  = rsp_flags_q;
  assign fifo_level     = level;
endmodule

// File: tb/tb_alu_slot_issuer.sv
// tb/tb_alu_slot_issuer.sv - directed self-checking bench for alu_slot_issuer
module tb_alu_slot_issuer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] fifo_level;
  logic [3:0] issued_count;
  int pass_cnt = 0;
  int total_cnt = 0;

  alu_slot_issuer_if #(.TAG_W(4)) bus ();

  alu_slot_issuer #(.DEPTH(4), .TAG_W(4), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .fifo_level   (fifo_level),
    .issued_count (issued_count)
  );

  always #5 clk = ~clk;

  // Sequenced ALU: IDLE -> EXEC -> WB, result registered on the WB edge.
  logic [1:0] alu_state;
  logic [4:0] sum;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_state        <= 2'd0;
      bus.alu_result   <= 4'd0;
      bus.alu_carry    <= 1'b0;
      bus.alu_zero     <= 1'b0;
      bus.alu_overflow <= 1'b0;
    end else begin
      alu_state <= (alu_state == 2'd2) ? 2'd0 : alu_state + 2'd1;
      if (alu_state == 2'd2) begin
        case (bus.alu_op)
          2'b00: begin
            sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
            bus.alu_result   <= sum[3:0];
            bus.alu_carry    <= sum[4];
            bus.alu_zero     <= (sum[3:0] == 4'd0);
            bus.alu_overflow <= (bus.alu_a[3] == bus.alu_b[3]) && (sum[3] != bus.alu_a[3]);
          end
          2'b01: begin
            sum = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
            bus.alu_result   <= sum[3:0];
            bus.alu_carry    <= (bus.alu_a < bus.alu_b);
            bus.alu_zero     <= (sum[3:0] == 4'd0);
            bus.alu_overflow <= (bus.alu_a[3] != bus.alu_b[3]) && (sum[3] != bus.alu_a[3]);
          end
          2'b10: begin
            bus.alu_result   <= bus.alu_a & bus.alu_b;
            bus.alu_carry    <= 1'b0;
            bus.alu_zero     <= ((bus.alu_a & bus.alu_b) == 4'd0);
            bus.alu_overflow <= 1'b0;
          end
          default: begin
            bus.alu_result   <= bus.alu_a | bus.alu_b;
            bus.alu_carry    <= 1'b0;
            bus.alu_zero     <= ((bus.alu_a | bus.alu_b) == 4'd0);
            bus.alu_overflow <= 1'b0;
          end
        endcase
      end
    end
  end

  task automatic drive_cmd(input logic v, input logic [3:0] a, input logic [3:0] b,
                           input logic [1:0] op, input logic [3:0] tag);
    bus.cmd_valid = v;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_op    = op;
    bus.cmd_tag   = tag;
  endtask

  // Returns at the negedge inside cycle 0 after release.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_cmd(1'b0, 4'd0, 4'd0, 2'd0, 4'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total_cnt++;
    if (bus.cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b want 1", bus.cmd_ready);
    else pass_cnt++;
    total_cnt++;
    if (fifo_level !== 3'd0) $display("FAIL reset_level got %0d want 0", fifo_level);
    else pass_cnt++;
    total_cnt++;
    if (issued_count !== 4'd0) $display("FAIL reset_issued got %0d want 0", issued_count);
    else pass_cnt++;
    total_cnt++;
    if ({bus.rsp_valid, bus.rsp_tag, bus.rsp_result, bus.rsp_flags} !== 12'd0)
      $display("FAIL reset_rsp got %b/%h/%h/%b want all 0", bus.rsp_valid, bus.rsp_tag,
               bus.rsp_result, bus.rsp_flags);
    else pass_cnt++;
    total_cnt++;
    if ({bus.alu_a, bus.alu_b, bus.alu_op} !== 10'd0)
      $display("FAIL reset_alu got %h/%h/%b want 0", bus.alu_a, bus.alu_b, bus.alu_op);
    else pass_cnt++;
  endtask

  task automatic test_single_add();
    do_reset();
    for (int k = 0; k < 11; k++) begin
      total_cnt++;
      if (bus.rsp_valid !== (k == 7))
        $display("FAIL add_pulse cycle %0d got %b want %b", k, bus.rsp_valid, (k == 7));
      else pass_cnt++;
      if (k == 7) begin
        total_cnt++;
        if ({bus.rsp_tag, bus.rsp_result, bus.rsp_flags} !== {4'd1, 4'd8, 3'b001})
          $display("FAIL add_rsp got tag %0d res %h flags %b want tag 1 res 8 flags 001",
                   bus.rsp_tag, bus.rsp_result, bus.rsp_flags);
        else pass_cnt++;
      end
      if (k == 0) drive_cmd(1'b1, 4'd5, 4'd3, 2'b00, 4'd1);
      else drive_cmd(1'b0, 4'd0, 4'd0, 2'd0, 4'd0);
      @(negedge clk);
    end
  endtask

  task automatic test_ops();
    logic [10:0] exp_rsp;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      total_cnt++;
      if (bus.rsp_valid !== (k == 7 || k == 10 || k == 13))
        $display("FAIL ops_pulse cycle %0d got %b", k, bus.rsp_valid);
      else pass_cnt++;
      if (bus.rsp_valid) begin
        case (k)
          7:       exp_rsp = {4'd2, 4'hE, 3'b100};
          10:      exp_rsp = {4'd3, 4'h0, 3'b010};
          default: exp_rsp = {4'd4, 4'hF, 3'b000};
        endcase
        total_cnt++;
        if ({bus.rsp_tag, bus.rsp_result, bus.rsp_flags} !== exp_rsp)
          $display("FAIL ops_rsp cycle %0d got %h/%h/%b want %h/%h/%b", k, bus.rsp_tag,
                   bus.rsp_result, bus.rsp_flags, exp_rsp[10:7], exp_rsp[6:3], exp_rsp[2:0]);
        else pass_cnt++;
      end
      case (k)
        0:       drive_cmd(1'b1, 4'h3, 4'h5, 2'b01, 4'd2);
        1:       drive_cmd(1'b1, 4'hA, 4'h5, 2'b10, 4'd3);
        2:       drive_cmd(1'b1, 4'hF, 4'h0, 2'b11, 4'd4);
        default: drive_cmd(1'b0, 4'd0, 4'd0, 2'd0, 4'd0);
      endcase
      @(negedge clk);
    end
  endtask

  task automatic test_fifo_full();
    logic [9:0] rdy_tab;
    logic [3:0] next_tag;
    int rsp_seen;
    rdy_tab  = 10'b1001011111;
    next_tag = 4'd0;
    rsp_seen = 0;
    do_reset();
    for (int k = 0; k < 28; k++) begin
      if (k < 10) begin
        total_cnt++;
        if (bus.cmd_ready !== rdy_tab[k])
          $display("FAIL full_ready cycle %0d got %b want %b", k, bus.cmd_ready, rdy_tab[k]);
        else pass_cnt++;
      end
      total_cnt++;
      if (fifo_level > 3'd4) $display("FAIL full_level cycle %0d got %0d want <=4", k, fifo_level);
      else pass_cnt++;
      total_cnt++;
      if (bus.rsp_valid !== (k >= 7 && (k - 7) % 3 == 0 && k <= 25))
        $display("FAIL full_pulse cycle %0d got %b", k, bus.rsp_valid);
      else pass_cnt++;
      if (bus.rsp_valid) begin
        total_cnt++;
        if ({bus.rsp_tag, bus.rsp_result} !== {4'(rsp_seen), 4'(rsp_seen + 1)})
          $display("FAIL full_order got tag %0d res %0d want tag %0d res %0d",
                   bus.rsp_tag, bus.rsp_result, rsp_seen, rsp_seen + 1);
        else pass_cnt++;
        rsp_seen++;
      end
      if (k == 12) begin
        total_cnt++;
        if (issued_count !== 4'd4 || rsp_seen != 2)
          $display("FAIL full_issued_mid got issued %0d rsp %0d want issued 4 rsp 2",
                   issued_count, rsp_seen);
        else pass_cnt++;
      end
      if (k < 10) begin
        drive_cmd(1'b1, next_tag, 4'd1, 2'b00, next_tag);
        if (bus.cmd_ready) next_tag = next_tag + 4'd1;
      end else begin
        drive_cmd(1'b0, 4'd0, 4'd0, 2'd0, 4'd0);
      end
      @(negedge clk);
    end
    total_cnt++;
    if (next_tag !== 4'd7 || rsp_seen != 7 || issued_count !== 4'd7)
      $display("FAIL full_totals got accepted %0d rsp %0d issued %0d want 7/7/7",
               next_tag, rsp_seen, issued_count);
    else pass_cnt++;
  endtask

  task automatic test_bubble();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      total_cnt++;
      if (bus.rsp_valid !== 1'b0 || issued_count !== 4'd0 ||
          {bus.alu_a, bus.alu_b, bus.alu_op} !== 10'd0)
        $display("FAIL bubble cycle %0d got rsp %b issued %0d alu %h/%h/%b want all 0",
                 k, bus.rsp_valid, issued_count, bus.alu_a, bus.alu_b, bus.alu_op);
      else pass_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midflight();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (k < 3) drive_cmd(1'b1, 4'd9, 4'd2, 2'b00, 4'(8 + k));
      else drive_cmd(1'b0, 4'd0, 4'd0, 2'd0, 4'd0);
      @(negedge clk);
    end
    total_cnt++;
    if (issued_count !== 4'd2 || bus.alu_a !== 4'd9)
      $display("FAIL midflight_pre got issued %0d alu_a %0d want 2/9", issued_count, bus.alu_a);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({bus.rsp_valid, fifo_level, issued_count, bus.alu_a, bus.alu_b, bus.alu_op} !== 18'd0 ||
        bus.cmd_ready !== 1'b1)
      $display("FAIL midflight_async got rsp %b lvl %0d issued %0d alu_a %0d ready %b want 0/0/0/0/1",
               bus.rsp_valid, fifo_level, issued_count, bus.alu_a, bus.cmd_ready);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 11; k++) begin
      total_cnt++;
      if (bus.rsp_valid !== (k == 7))
        $display("FAIL midflight_pulse cycle %0d got %b want %b", k, bus.rsp_valid, (k == 7));
      else pass_cnt++;
      if (k == 7) begin
        total_cnt++;
        if ({bus.rsp_tag, bus.rsp_result} !== {4'd5, 4'd2})
          $display("FAIL midflight_rsp got tag %0d res %0d want tag 5 res 2",
                   bus.rsp_tag, bus.rsp_result);
        else pass_cnt++;
      end
      if (k == 0) drive_cmd(1'b1, 4'd1, 4'd1, 2'b00, 4'd5);
      else drive_cmd(1'b0, 4'd0, 4'd0, 2'd0, 4'd0);
      @(negedge clk);
    end
  endtask

  task automatic test_counter_wrap();
    int accepted;
    accepted = 0;
    do_reset();
    for (int k = 0; k < 53; k++) begin
      if (k == 50) begin
        total_cnt++;
        if (issued_count !== 4'd0) $display("FAIL wrap_16 got %0d want 0", issued_count);
        else pass_cnt++;
      end
      if (k == 51) begin
        total_cnt++;
        if (issued_count !== 4'd1) $display("FAIL wrap_17 got %0d want 1", issued_count);
        else pass_cnt++;
      end
      if (accepted < 17) begin
        drive_cmd(1'b1, 4'd2, 4'd2, 2'b10, 4'(accepted));
        if (bus.cmd_ready) accepted++;
      end else begin
        drive_cmd(1'b0, 4'd0, 4'd0, 2'd0, 4'd0);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    drive_cmd(1'b0, 4'd0, 4'd0, 2'd0, 4'd0);
    test_reset();
    test_single_add();
    test_ops();
    test_fifo_full();
    test_bubble();
    test_reset_midflight();
    test_counter_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
